// File: rtl/ltf_pkg.sv
// Shared constants and types for the LTF channel estimator.
// Bin k carries subcarrier k-32. LTF_NZ marks bins that carry a pilot
// symbol of the L sequence (subcarriers -26..-1 and +1..+26). LTF_NEG marks
// the bins whose L sequence value is -1.
package ltf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYM1 = 2'd1,
    ST_SYM2 = 2'd2
  } ltf_state_e;

  localparam int unsigned LTF_BINS = 64;
  localparam logic [5:0]  LTF_LAST = 6'd63;

  // Bits 6..31 and 33..58 set: subcarriers -26..-1 and +1..+26.
  localparam logic [63:0] LTF_NZ  = 64'h07FF_FFFE_FFFF_FFC0;
  // Bins 8,9,12,14,21,22,25,27 and 34,35,38,40,42..46,49,50,52,54.
  localparam logic [63:0] LTF_NEG = 64'h0056_7D4C_0A60_5300;

endpackage

// File: rtl/ltf_chan_est_if.sv
// Streaming interface of the LTF channel estimator.
//   in_start  : one-cycle pulse arming capture of a new LTF pair
//   in_valid  : qualifies in_data
//   in_data   : FFT bin {I, Q}, two's complement
//   out_valid : qualifies out_data / out_idx
//   out_data  : channel estimate {I, Q}
//   out_idx   : bin index of out_data
//   out_done  : pulses with the estimate for bin 63
//   busy      : high while a pair is being captured
// master drives the FFT side, slave is the estimator.
interface ltf_chan_est_if #(
  parameter int DW = 16
);
  logic            in_start;
  logic            in_valid;
  logic [2*DW-1:0] in_data;
  logic            out_valid;
  logic [2*DW-1:0] out_data;
  logic [5:0]      out_idx;
  logic            out_done;
  logic            busy;

  modport master (
    output in_start, in_valid, in_data,
    input  out_valid, out_data, out_idx, out_done, busy
  );

  modport slave (
    input  in_start, in_valid, in_data,
    output out_valid, out_data, out_idx, out_done, busy
  );
endinterface

// File: rtl/ltf_sym_buf.sv
// 64-entry holding buffer for the first LTF symbol.
//   clk     : clock, writes on the rising edge
//   wr_en   : write strobe
//   wr_addr : write bin index
//   wr_data : bin value {I, Q}
//   rd_addr : read bin index
//   rd_data : asynchronous read data
// Contents are not reset; every entry is written before it is read.
module ltf_sym_buf
  import ltf_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic            clk,
  input  logic            wr_en,
  input  logic [5:0]      wr_addr,
  input  logic [2*DW-1:0] wr_data,
  input  logic [5:0]      rd_addr,
  output logic [2*DW-1:0] rd_data
);

  logic [2*DW-1:0] mem_r [LTF_BINS];

  // Single write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_r[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/ltf_chan_est.sv
// LTF least-squares channel estimator.
// Captures the first long training symbol into a buffer, then averages each
// bin of the second symbol with the stored one and multiplies by the known
// L sequence value (+1, -1 or 0) to give a per-bin channel estimate.
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   bus  : slave side of ltf_chan_est_if (in_start/in_valid/in_data in,
//          out_valid/out_data/out_idx/out_done/busy out)
module ltf_chan_est
  import ltf_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  ltf_chan_est_if.slave bus
);

  ltf_state_e      state_r, state_nxt_s;
  logic [5:0]      cnt_r, cnt_nxt_s;
  logic            wr_en_s;
  logic [5:0]      wr_addr_s;
  logic            sym2_take_s;
  logic            last_bin_s;
  logic [2*DW-1:0] rd_data_s;

  logic signed [DW:0]   sum_i_s, sum_q_s;
  logic        [DW-1:0] avg_i_s, avg_q_s;
  logic [2*DW-1:0]      est_s;

  logic            out_valid_r;
  logic [2*DW-1:0] out_data_r;
  logic [5:0]      out_idx_r;
  logic            out_done_r;
  logic            busy_r;

  // Negation with the most negative value clamped to the most positive.
  function automatic logic [DW-1:0] neg_sat(input logic [DW-1:0] v);
    logic [DW-1:0] res;
    if (v == {1'b1, {(DW-1){1'b0}}}) begin
      res = {1'b0, {(DW-1){1'b1}}};
    end else begin
      res = (~v) + {{(DW-1){1'b0}}, 1'b1};
    end
    return res;
  endfunction

  assign last_bin_s = (cnt_r == LTF_LAST);

  ltf_sym_buf #(.DW(DW)) u_buf (
    .clk     (clk),
    .wr_en   (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (bus.in_data),
    .rd_addr (cnt_r),
    .rd_data (rd_data_s)
  );

  // State and bin counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      cnt_r   <= 6'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Next-state decode; in_start overrides everything.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.in_start) begin
      state_nxt_s = ST_SYM1;
    end else if (bus.in_valid && last_bin_s) begin
      case (state_r)
        ST_SYM1: state_nxt_s = ST_SYM2;
        ST_SYM2: state_nxt_s = ST_IDLE;
        ST_IDLE: state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Per-state control: buffer write, SYM2 accept and counter advance.
  always_comb begin
    wr_en_s     = 1'b0;
    wr_addr_s   = cnt_r;
    sym2_take_s = 1'b0;
    cnt_nxt_s   = cnt_r;
    if (bus.in_start) begin
      // A bin arriving with the start pulse is bin 0 of the new SYM1.
      wr_en_s   = bus.in_valid;
      wr_addr_s = 6'd0;
      cnt_nxt_s = bus.in_valid ? 6'd1 : 6'd0;
    end else if (bus.in_valid) begin
      case (state_r)
        ST_SYM1: begin
          wr_en_s   = 1'b1;
          cnt_nxt_s = cnt_r + 6'd1;
        end
        ST_SYM2: begin
          sym2_take_s = 1'b1;
          cnt_nxt_s   = cnt_r + 6'd1;
        end
        ST_IDLE: cnt_nxt_s = cnt_r;
        default: cnt_nxt_s = cnt_r;
      endcase
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // One extra sign bit keeps the pair sum exact; the >>>1 result fits DW.
  assign sum_i_s = $signed({rd_data_s[2*DW-1], rd_data_s[2*DW-1:DW]})
                 + $signed({bus.in_data[2*DW-1], bus.in_data[2*DW-1:DW]});
  assign sum_q_s = $signed({rd_data_s[DW-1], rd_data_s[DW-1:0]})
                 + $signed({bus.in_data[DW-1], bus.in_data[DW-1:0]});
  assign avg_i_s = sum_i_s[DW:1];
  assign avg_q_s = sum_q_s[DW:1];

  // Apply the L sequence value of the current bin.
  always_comb begin
    est_s = '0;
    if (!LTF_NZ[cnt_r]) begin
      est_s = '0;
    end else if (LTF_NEG[cnt_r]) begin
      est_s = {neg_sat(avg_i_s), neg_sat(avg_q_s)};
    end else begin
      est_s = {avg_i_s, avg_q_s};
    end
  end

  // Registered outputs; only an accepted SYM2 bin produces out_valid.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_idx_r   <= 6'd0;
      out_done_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      out_valid_r <= sym2_take_s;
      out_done_r  <= sym2_take_s && last_bin_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      if (sym2_take_s) begin
        out_data_r <= est_s;
        out_idx_r  <= cnt_r;
      end
    end
  end

  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_idx   = out_idx_r;
  assign bus.out_done  = out_done_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_ltf_chan_est.sv
// Self-checking bench for ltf_chan_est: randomized LTF pairs compared every
// cycle against a behavioural model built from the L sequence table, plus
// literal checks of sign/null mapping, averaging, saturation, restart and
// reset behaviour.
module tb_ltf_chan_est;

  logic clk;
  logic rstn;

  ltf_chan_est_if #(.DW(16)) bus ();

  ltf_chan_est #(.DW(16)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // L sequence for subcarriers -26..+26 (index sc+26).
  int ltf_l [53] = '{1, 1, -1, -1, 1, 1, -1, 1, -1, 1, 1, 1, 1, 1, 1, -1, -1, 1, 1, -1, 1, -1, 1, 1, 1, 1,
                     0,
                     1, -1, -1, 1, 1, -1, 1, -1, 1, -1, -1, -1, -1, -1, 1, 1, -1, -1, 1, -1, 1, -1, 1, 1, 1, 1};

  int total = 0;
  int bad   = 0;

  // Model state
  int          m_mode = 0;      // 0 idle, 1 capturing first symbol, 2 averaging
  int          m_cnt  = 0;
  logic [31:0] m_buf [64];
  bit          pend_v = 1'b0, pend_done = 1'b0, pend_busy = 1'b0;
  logic [31:0] pend_data = 32'd0;
  logic [5:0]  pend_idx = 6'd0;
  bit          exp_v, exp_done, exp_busy;
  logic [31:0] exp_data;
  logic [5:0]  exp_idx;

  logic [31:0] d1 [64];
  logic [31:0] d2 [64];
  logic [31:0] cap [64];
  int          n_valid = 0, n_done = 0, nv_rst = 0;
  int          nv_base = 0, nd_base = 0;
  int          lit_sel = 0, lit_seen = 0;

  function automatic int lsign(input int k);
    int sc;
    sc = k - 32;
    if (sc < -26 || sc > 26) return 0;
    return ltf_l[sc + 26];
  endfunction

  // Estimate from the two raw bins using plain integer arithmetic.
  function automatic logic [31:0] est(input logic [31:0] a, input logic [31:0] b, input int k);
    int s, ai, aq;
    s  = lsign(k);
    ai = (int'($signed(a[31:16])) + int'($signed(b[31:16]))) >>> 1;
    aq = (int'($signed(a[15:0]))  + int'($signed(b[15:0])))  >>> 1;
    ai = s * ai;
    aq = s * aq;
    if (ai > 32767) ai = 32767;
    if (aq > 32767) aq = 32767;
    return {ai[15:0], aq[15:0]};
  endfunction

  task automatic model_step(input bit s, input bit v, input logic [31:0] d);
    pend_v    = 1'b0;
    pend_done = 1'b0;
    if (s) begin
      m_mode = 1;
      m_cnt  = 0;
      if (v) begin
        m_buf[0] = d;
        m_cnt    = 1;
      end
    end else if (v && m_mode == 1) begin
      m_buf[m_cnt] = d;
      if (m_cnt == 63) m_mode = 2;
      m_cnt = (m_cnt + 1) % 64;
    end else if (v && m_mode == 2) begin
      pend_v    = 1'b1;
      pend_idx  = 6'(m_cnt);
      pend_data = est(m_buf[m_cnt], d, m_cnt);
      pend_done = (m_cnt == 63);
      if (m_cnt == 63) m_mode = 0;
      m_cnt = (m_cnt + 1) % 64;
    end
    pend_busy = (m_mode != 0);
  endtask

  task automatic model_reset();
    m_mode    = 0;
    m_cnt     = 0;
    pend_v    = 1'b0;
    pend_done = 1'b0;
    pend_busy = 1'b0;
  endtask

  task automatic cycle(input bit s, input bit v, input logic [31:0] d);
    bus.in_start = s;
    bus.in_valid = v;
    bus.in_data  = d;
    model_step(s, v, d);
    @(posedge clk);
    #1;
  endtask

  task automatic send_sym(input bit second, input bit gaps, input int first);
    for (int k = first; k < 64; k++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        for (int j = 0; j < g; j++) cycle(1'b0, 1'b0, $urandom);
      end
      cycle(1'b0, 1'b1, second ? d2[k] : d1[k]);
    end
  endtask

  task automatic fill_random();
    for (int k = 0; k < 64; k++) begin
      d1[k] = $urandom;
      d2[k] = $urandom;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, want, $time);
    end
  endtask

  // Expected output for the cycle the DUT has just registered.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      exp_v    <= 1'b0;
      exp_done <= 1'b0;
      exp_busy <= 1'b0;
      exp_data <= 32'd0;
      exp_idx  <= 6'd0;
    end else begin
      exp_v    <= pend_v;
      exp_done <= pend_done;
      exp_busy <= pend_busy;
      exp_data <= pend_data;
      exp_idx  <= pend_idx;
    end
  end

  // Compare process: model checks every cycle, reset checks, literal pins.
  always @(negedge clk) begin
    if (!rstn) begin
      chk("rst_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_data",  bus.out_data,       32'd0);
      chk("rst_idx",   32'(bus.out_idx),   32'd0);
      chk("rst_done",  32'(bus.out_done),  32'd0);
      chk("rst_busy",  32'(bus.busy),      32'd0);
      nv_rst = n_valid;
    end else begin
      chk("out_valid", 32'(bus.out_valid), 32'(exp_v));
      chk("out_done",  32'(bus.out_done),  32'(exp_done));
      chk("busy",      32'(bus.busy),      32'(exp_busy));
      if (exp_v) begin
        chk("out_idx",  32'(bus.out_idx), 32'(exp_idx));
        chk("out_data", bus.out_data,     exp_data);
      end
      if (bus.out_valid) begin
        cap[bus.out_idx] = bus.out_data;
        n_valid++;
      end
      if (bus.out_done) n_done++;
    end
    if (lit_sel != lit_seen) begin
      case (lit_sel)
        1: begin
          chk("model_sc-24", est(32'h1000_0000, 32'h1000_0000, 8),  32'hF000_0000);
          chk("model_sat",   est(32'h8000_0000, 32'h8000_0000, 8),  32'h7FFF_0000);
          chk("model_floor", est(32'hFFFF_0000, 32'h0000_0000, 33), 32'hFFFF_0000);
          chk("sign_bin6",   cap[6],  32'h1000_0000);
          chk("sign_bin8",   cap[8],  32'hF000_0000);
          chk("null_bin32",  cap[32], 32'h0000_0000);
          for (int b = 0; b < 6; b++) chk("null_low", cap[b], 32'h0000_0000);
        end
        2: begin
          chk("avg_bin33",  cap[33], 32'h2000_0000);
          chk("avg_bin38",  cap[38], 32'hE000_0000);  // sc +6 carries -1
          chk("avg_bin36",  cap[36], 32'h0000_0000);
          chk("sat_bin8",   cap[8],  32'h7FFF_0000);
          chk("gap_count",  32'(n_valid - nv_base), 32'd64);
          chk("done_count", 32'(n_done - nd_base),  32'd1);
        end
        3: chk("abort_quiet", 32'(bus.out_valid), 32'd0);
        4: chk("restart_bin40", cap[40], 32'hFE00_FFE0);
        5: chk("idle_ignore", 32'(n_valid - nv_rst), 32'd0);
        default: ;
      endcase
      lit_seen = lit_sel;
    end
  end

  initial begin
    rstn         = 1'b0;
    bus.in_start = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 32'd0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    cycle(1'b0, 1'b0, 32'd0);

    // Constant symbols: sign and null mapping.
    for (int k = 0; k < 64; k++) begin
      d1[k] = 32'h1000_0000;
      d2[k] = 32'h1000_0000;
    end
    cycle(1'b1, 1'b0, 32'd0);
    send_sym(1'b0, 1'b0, 0);
    send_sym(1'b1, 1'b0, 0);
    cycle(1'b0, 1'b0, 32'd0);
    lit_sel = 1;
    cycle(1'b0, 1'b0, 32'd0);

    // Random data with gaps, averaging and saturation bins.
    fill_random();
    d1[33] = 32'h1000_0000; d2[33] = 32'h3000_0000;
    d1[38] = 32'h1000_0000; d2[38] = 32'h3000_0000;
    d1[36] = 32'h0001_0000; d2[36] = 32'h0000_0000;
    d1[8]  = 32'h8000_0000; d2[8]  = 32'h8000_0000;
    nv_base = n_valid;
    nd_base = n_done;
    cycle(1'b1, 1'b0, 32'd0);
    send_sym(1'b0, 1'b1, 0);
    send_sym(1'b1, 1'b1, 0);
    cycle(1'b0, 1'b0, 32'd0);
    lit_sel = 2;
    cycle(1'b0, 1'b0, 32'd0);

    // Restart during SYM2 at bin 20, then a clean pair.
    fill_random();
    cycle(1'b1, 1'b0, 32'd0);
    send_sym(1'b0, 1'b1, 0);
    for (int k = 0; k < 20; k++) cycle(1'b0, 1'b1, d2[k]);
    fill_random();
    d1[40] = 32'h0100_0010;
    d2[40] = 32'h0300_0030;
    cycle(1'b1, 1'b1, d1[0]);
    lit_sel = 3;
    send_sym(1'b0, 1'b1, 1);
    send_sym(1'b1, 1'b1, 0);
    cycle(1'b0, 1'b0, 32'd0);
    lit_sel = 4;
    cycle(1'b0, 1'b0, 32'd0);

    // Reset in the middle of SYM2, then in_valid without in_start.
    fill_random();
    cycle(1'b1, 1'b0, 32'd0);
    send_sym(1'b0, 1'b0, 0);
    for (int k = 0; k < 30; k++) cycle(1'b0, 1'b1, d2[k]);
    #2;
    rstn         = 1'b0;
    bus.in_start = 1'b0;
    bus.in_valid = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int k = 0; k < 10; k++) cycle(1'b0, 1'b1, $urandom);
    cycle(1'b0, 1'b0, 32'd0);
    lit_sel = 5;
    cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b0, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
